// File: rtl/risc_run_ctrl.sv
// Run controller for the pipelined RISC core: reset sequencing, pipeline
// enable gating, free-run / step / pause and halt, breakpoint, timeout stops.
module risc_run_ctrl #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] cpu_pc,
  input  logic        cpu_halt,
  output logic        cpu_rst_n,
  output logic        cpu_en,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic        bp_hit,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RUN     = 3'd2,
    S_STEP    = 3'd3,
    S_PAUSED  = 3'd4,
    S_HALTED  = 3'd5,
    S_TIMEOUT = 3'd6
  } state_e;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_STEP   = 2'd1;
  localparam logic [1:0] OP_PAUSE  = 2'd2;
  localparam logic [1:0] OP_RESUME = 2'd3;

  localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_e      st_q, st_d;
  logic [31:0] cnt_d, rem_q, rem_d, rcnt_q, rcnt_d;
  logic        bp_d, sup_q, sup_d;
  logic        acc, is_start, is_step, is_pause, is_resume;
  logic        tmo, bp_match;
  logic [31:0] cnt_inc;

  assign state = st_q;

  assign acc       = cmd_valid & cmd_ready;
  assign is_start  = acc & (cmd_op == OP_START);
  assign is_step   = acc & (cmd_op == OP_STEP);
  assign is_pause  = acc & (cmd_op == OP_PAUSE);
  assign is_resume = acc & (cmd_op == OP_RESUME);

  assign tmo      = (cycle_cnt == TMO_LAST);
  assign bp_match = bp_en & (cpu_pc == bp_addr) & ~sup_q;
  assign cnt_inc  = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 32'd1;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cycle_cnt;
    rem_d  = rem_q;
    rcnt_d = rcnt_q;
    bp_d   = bp_hit;
    sup_d  = sup_q;
    if (is_start) begin
      st_d   = S_RESET;
      cnt_d  = '0;
      rem_d  = '0;
      rcnt_d = '0;
      bp_d   = 1'b0;
      sup_d  = 1'b0;
    end else begin
      unique case (st_q)
        S_RESET: begin
          if (rcnt_q == RST_LAST) st_d = S_RUN;
          else rcnt_d = rcnt_q + 32'd1;
        end
        S_RUN: begin
          cnt_d = cnt_inc;
          sup_d = 1'b0;
          if (cpu_halt) st_d = S_HALTED;
          else if (tmo) st_d = S_TIMEOUT;
          else if (bp_match) begin
            st_d = S_PAUSED;
            bp_d = 1'b1;
          end else if (is_pause) st_d = S_PAUSED;
        end
        S_STEP: begin
          cnt_d = cnt_inc;
          rem_d = rem_q - 32'd1;
          if (cpu_halt) st_d = S_HALTED;
          else if (tmo) st_d = S_TIMEOUT;
          else if (rem_q == 32'd1 || is_pause) st_d = S_PAUSED;
        end
        S_PAUSED: begin
          if (is_resume) begin
            st_d  = S_RUN;
            sup_d = 1'b1;
            bp_d  = 1'b0;
          end else if (is_step) begin
            st_d  = S_STEP;
            rem_d = (cmd_arg == '0) ? 32'd1 : cmd_arg;
            bp_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      cycle_cnt <= '0;
      rem_q     <= '0;
      rcnt_q    <= '0;
      bp_hit    <= 1'b0;
      sup_q     <= 1'b0;
      cpu_en    <= 1'b0;
      cpu_rst_n <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      st_q      <= st_d;
      cycle_cnt <= cnt_d;
      rem_q     <= rem_d;
      rcnt_q    <= rcnt_d;
      bp_hit    <= bp_d;
      sup_q     <= sup_d;
      cpu_en    <= (st_d == S_RUN) || (st_d == S_STEP);
      cpu_rst_n <= !((st_d == S_IDLE) || (st_d == S_RESET));
      cmd_ready <= (st_d != S_RESET);
      done      <= ((st_d == S_HALTED) || (st_d == S_TIMEOUT))
                   && (st_d != st_q);
    end
  end

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Scoreboard bench for risc_run_ctrl: stimulus queues expected snapshots
// and done pulses; a negedge monitor pops and compares them.
module tb_risc_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_arg = '0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] cpu_pc = '0;
  logic        cpu_halt = 1'b0;
  logic        cmd_ready, cpu_rst_n, cpu_en, bp_hit, done;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;

  risc_run_ctrl #(.RST_CYCLES(4), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_pc(cpu_pc), .cpu_halt(cpu_halt),
    .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en),
    .state(state), .cycle_cnt(cycle_cnt),
    .bp_hit(bp_hit), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    string       nm;
    logic [2:0]  st;
    logic        en, rn, rdy, bp, dn;
    logic [31:0] cnt;
  } snap_t;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] cnt;
  } done_t;

  snap_t sq[$];
  done_t dq[$];
  int    checks = 0;
  int    failures = 0;
  logic  end_req = 1'b0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic exp_s(input string nm, input logic [2:0] st,
                       input logic en, input logic rn, input logic rdy,
                       input logic [31:0] cnt, input logic bp,
                       input logic dn);
    snap_t s;
    s.tag = cyc; s.nm = nm; s.st = st; s.en = en; s.rn = rn;
    s.rdy = rdy; s.cnt = cnt; s.bp = bp; s.dn = dn;
    sq.push_back(s);
  endtask

  task automatic exp_done(input logic [2:0] st, input logic [31:0] cnt);
    done_t d;
    d.st = st; d.cnt = cnt;
    dq.push_back(d);
  endtask

  always @(negedge clk) begin
    snap_t s;
    done_t d;
    while (sq.size() > 0 && sq[0].tag <= cyc) begin
      s = sq.pop_front();
      checks++;
      if (s.tag != cyc || state !== s.st || cpu_en !== s.en ||
          cpu_rst_n !== s.rn || cmd_ready !== s.rdy ||
          cycle_cnt !== s.cnt || bp_hit !== s.bp || done !== s.dn) begin
        failures++;
        $display("FAIL %s: got st=%0d en=%b rstn=%b rdy=%b cnt=%0d bp=%b done=%b, want st=%0d en=%b rstn=%b rdy=%b cnt=%0d bp=%b done=%b (tag %0d cyc %0d)",
                 s.nm, state, cpu_en, cpu_rst_n, cmd_ready, cycle_cnt,
                 bp_hit, done, s.st, s.en, s.rn, s.rdy, s.cnt, s.bp,
                 s.dn, s.tag, cyc);
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL done_pulse: got done=1 st=%0d cnt=%0d, want no pulse",
                 state, cycle_cnt);
      end else begin
        d = dq.pop_front();
        if (state !== d.st || cycle_cnt !== d.cnt) begin
          failures++;
          $display("FAIL done_pulse: got st=%0d cnt=%0d, want st=%0d cnt=%0d",
                   state, cycle_cnt, d.st, d.cnt);
        end
      end
    end
    if (end_req) begin
      checks++;
      if (sq.size() != 0 || dq.size() != 0) begin
        failures++;
        $display("FAIL drain: got %0d snapshots %0d done pulses pending, want 0 0",
                 sq.size(), dq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by 100000, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    exp_s("rst_idle", 0, 0, 0, 1, 0, 0, 0);
    rst = 1'b0;
    tick(1);
    exp_s("idle_hold", 0, 0, 0, 1, 0, 0, 0);

    cmd(2'd0, 0);
    exp_s("start_rst0", 1, 0, 0, 0, 0, 0, 0);
    tick(3);
    exp_s("start_rst3", 1, 0, 0, 0, 0, 0, 0);
    tick(1);
    exp_s("run0", 2, 1, 1, 1, 0, 0, 0);
    tick(37);
    exp_s("run37", 2, 1, 1, 1, 37, 0, 0);
    cpu_halt = 1'b1;
    exp_done(5, 38);
    tick(1);
    cpu_halt = 1'b0;
    exp_s("halted", 5, 0, 1, 1, 38, 0, 1);
    tick(1);
    exp_s("halted_hold", 5, 0, 1, 1, 38, 0, 0);
    cmd(2'd3, 0);
    exp_s("halted_resume_ign", 5, 0, 1, 1, 38, 0, 0);

    cmd(2'd0, 0);
    tick(4);
    exp_s("run0_b", 2, 1, 1, 1, 0, 0, 0);
    bp_en = 1'b1;
    bp_addr = 32'h10;
    cpu_pc = 32'h4;
    tick(5);
    exp_s("run5", 2, 1, 1, 1, 5, 0, 0);
    cpu_pc = 32'h10;
    tick(1);
    exp_s("bp_pause", 4, 0, 1, 1, 6, 1, 0);
    tick(2);
    exp_s("bp_hold", 4, 0, 1, 1, 6, 1, 0);
    cmd(2'd3, 0);
    exp_s("resume_sup", 2, 1, 1, 1, 6, 0, 0);
    cpu_pc = 32'h14;
    tick(1);
    exp_s("run7", 2, 1, 1, 1, 7, 0, 0);
    cmd(2'd2, 0);
    exp_s("paused", 4, 0, 1, 1, 8, 0, 0);

    cmd(2'd1, 3);
    exp_s("step3_a", 3, 1, 1, 1, 8, 0, 0);
    tick(1);
    exp_s("step3_b", 3, 1, 1, 1, 9, 0, 0);
    tick(1);
    exp_s("step3_c", 3, 1, 1, 1, 10, 0, 0);
    tick(1);
    exp_s("step3_end", 4, 0, 1, 1, 11, 0, 0);
    cmd(2'd1, 0);
    exp_s("step0_a", 3, 1, 1, 1, 11, 0, 0);
    tick(1);
    exp_s("step0_end", 4, 0, 1, 1, 12, 0, 0);
    cpu_pc = 32'h10;
    cmd(2'd1, 2);
    exp_s("step2_a", 3, 1, 1, 1, 12, 0, 0);
    tick(1);
    exp_s("step2_b", 3, 1, 1, 1, 13, 0, 0);
    tick(1);
    exp_s("step2_end", 4, 0, 1, 1, 14, 0, 0);

    cmd(2'd3, 0);
    exp_s("resume2", 2, 1, 1, 1, 14, 0, 0);
    cpu_halt = 1'b1;
    exp_done(5, 15);
    cmd(2'd2, 0);
    cpu_halt = 1'b0;
    exp_s("pause_vs_halt", 5, 0, 1, 1, 15, 0, 1);

    bp_en = 1'b0;
    cpu_pc = '0;
    cmd(2'd0, 0);
    tick(4);
    exp_s("run0_c", 2, 1, 1, 1, 0, 0, 0);
    tick(49);
    exp_s("run49", 2, 1, 1, 1, 49, 0, 0);
    exp_done(6, 50);
    tick(1);
    exp_s("timeout", 6, 0, 1, 1, 50, 0, 1);
    cmd(2'd3, 0);
    exp_s("tmo_resume_ign", 6, 0, 1, 1, 50, 0, 0);
    cmd(2'd1, 4);
    exp_s("tmo_step_ign", 6, 0, 1, 1, 50, 0, 0);
    cmd(2'd0, 0);
    exp_s("restart", 1, 0, 0, 0, 0, 0, 0);
    tick(4);
    exp_s("run0_d", 2, 1, 1, 1, 0, 0, 0);
    cmd(2'd2, 0);
    exp_s("paused_d", 4, 0, 1, 1, 1, 0, 0);
    cmd(2'd1, 5);
    exp_s("step5_a", 3, 1, 1, 1, 1, 0, 0);
    tick(1);
    exp_s("step5_b", 3, 1, 1, 1, 2, 0, 0);

    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    tick(1);
    rst = 1'b0;
    cmd_valid = 1'b0;
    exp_s("rst_mid_step", 0, 0, 0, 1, 0, 0, 0);
    cmd(2'd3, 0);
    exp_s("idle_resume_ign", 0, 0, 0, 1, 0, 0, 0);
    cmd(2'd1, 2);
    exp_s("idle_step_ign", 0, 0, 0, 1, 0, 0, 0);

    tick(2);
    end_req = 1'b1;
  end

endmodule
